// File: rtl/lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
package lsu_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned WADDR_W         = 30;
    localparam int unsigned BE_W            = 4;
    localparam int unsigned REG_W           = 5;
    localparam int unsigned DEFAULT_TIMEOUT = 15;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } lsu_state_e;

    // Request fields captured at acceptance and held for the whole access.
    typedef struct packed {
        logic               we;
        logic [WADDR_W-1:0] addr;
        logic [BE_W-1:0]    be;
        logic [DATA_W-1:0]  wdata;
        logic [1:0]         size;
        logic               uns;
        logic [REG_W-1:0]   rd;
        logic [1:0]         off;
        logic               m2r;
        logic               rw;
    } lsu_req_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables/replication, misalign detection,
// and load lane extraction with sign/zero extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]        st_size_i,
    input  logic [1:0]        st_off_i,
    input  logic [DATA_W-1:0] st_wdata_i,
    input  logic [1:0]        ld_size_i,
    input  logic [1:0]        ld_off_i,
    input  logic              ld_unsigned_i,
    input  logic [DATA_W-1:0] ld_rdata_i,
    output logic [BE_W-1:0]   be_c,
    output logic [DATA_W-1:0] wdata_c,
    output logic              misalign_c,
    output logic [DATA_W-1:0] ld_data_c
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Store side; size 2'b11 falls through to word behaviour.
    always_comb begin
        be_c       = '1;
        wdata_c    = st_wdata_i;
        misalign_c = (st_off_i != 2'b00);
        case (st_size_i)
            SZ_BYTE: begin
                be_c       = BE_W'(4'b0001 << st_off_i);
                wdata_c    = {4{st_wdata_i[7:0]}};
                misalign_c = 1'b0;
            end
            SZ_HALF: begin
                be_c       = st_off_i[1] ? 4'b1100 : 4'b0011;
                wdata_c    = {2{st_wdata_i[15:0]}};
                misalign_c = st_off_i[0];
            end
            default: ;
        endcase
    end

    // Load side uses the offset latched with the request.
    always_comb begin
        byte_lane = ld_rdata_i[{ld_off_i, 3'b000} +: 8];
        half_lane = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
        ld_data_c = ld_rdata_i;
        case (ld_size_i)
            SZ_BYTE: ld_data_c = {{24{~ld_unsigned_i & byte_lane[7]}}, byte_lane};
            SZ_HALF: ld_data_c = {{16{~ld_unsigned_i & half_lane[15]}}, half_lane};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: issues one handshaked data-memory access at a time,
// builds the writeback record and stalls upstream while an access is open.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned CNT_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_valid,
    input  logic                ex_mem_read,
    input  logic                ex_mem_write,
    input  logic                ex_mem_to_reg,
    input  logic                ex_lui,
    input  logic [1:0]          ex_size,
    input  logic                ex_unsigned,
    input  logic [DATA_W-1:0]   ex_addr,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic [DATA_W-1:0]   ex_lui_field,
    input  logic [REG_W-1:0]    ex_rd,
    input  logic                ex_reg_write,
    output logic                stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [WADDR_W-1:0]  mem_addr,
    output logic [BE_W-1:0]     mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                wb_valid,
    output logic [REG_W-1:0]    wb_rd,
    output logic                wb_reg_write,
    output logic [DATA_W-1:0]   wb_data,
    output logic                exc_misalign,
    output logic                exc_timeout
);

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    lsu_req_t          req_q, req_d;
    logic              wb_valid_q, wb_valid_d;
    logic [REG_W-1:0]  wb_rd_q, wb_rd_d;
    logic              wb_rw_q, wb_rw_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              misalign_q, misalign_d;
    logic              timeout_q, timeout_d;

    logic [BE_W-1:0]   be_c;
    logic [DATA_W-1:0] wdata_c;
    logic              misalign_c;
    logic [DATA_W-1:0] ld_data_c;
    logic              is_mem_c;

    lsu_lane_align u_align (
        .st_size_i     (ex_size),
        .st_off_i      (ex_addr[1:0]),
        .st_wdata_i    (ex_wdata),
        .ld_size_i     (req_q.size),
        .ld_off_i      (req_q.off),
        .ld_unsigned_i (req_q.uns),
        .ld_rdata_i    (mem_rdata),
        .be_c          (be_c),
        .wdata_c       (wdata_c),
        .misalign_c    (misalign_c),
        .ld_data_c     (ld_data_c)
    );

    assign is_mem_c = ex_mem_write | ex_mem_read;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_rw_q    <= 1'b0;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_rw_q    <= wb_rw_d;
            wb_data_q  <= wb_data_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_rw_d    = 1'b0;
        wb_data_d  = wb_data_q;
        misalign_d = 1'b0;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    wb_rd_d = ex_rd;
                    if (!is_mem_c) begin
                        wb_valid_d = 1'b1;
                        wb_rw_d    = ex_reg_write;
                        wb_data_d  = ex_lui ? ex_lui_field : ex_addr;
                    end else if (misalign_c) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = ex_addr;
                        misalign_d = 1'b1;
                    end else begin
                        req_d.we    = ex_mem_write;
                        req_d.addr  = ex_addr[31:2];
                        req_d.be    = be_c;
                        req_d.wdata = wdata_c;
                        req_d.size  = ex_size;
                        req_d.uns   = ex_unsigned;
                        req_d.rd    = ex_rd;
                        req_d.off   = ex_addr[1:0];
                        req_d.m2r   = ex_mem_to_reg;
                        req_d.rw    = ex_reg_write;
                        cnt_d       = '0;
                        state_d     = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // An ack in the final allowed cycle beats the timeout.
                if (mem_ack) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = req_q.rd;
                    wb_rw_d    = ~req_q.we & req_q.rw;
                    wb_data_d  = (~req_q.we & req_q.m2r) ? ld_data_c : {req_q.addr, req_q.off};
                    cnt_d      = '0;
                    state_d    = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = req_q.rd;
                    wb_data_d  = {req_q.addr, req_q.off};
                    timeout_d  = 1'b1;
                    cnt_d      = '0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall        = (state_q == ACCESS);
    assign mem_req      = (state_q == ACCESS);
    assign mem_we       = req_q.we;
    assign mem_addr     = req_q.addr;
    assign mem_be       = req_q.be;
    assign mem_wdata    = req_q.wdata;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_rw_q;
    assign wb_data      = wb_data_q;
    assign exc_misalign = misalign_q;
    assign exc_timeout  = timeout_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed plan steps plus random ops against an
// arithmetic reference model of lane steering and writeback selection.
module tb_mem_stage_lsu;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0;
    logic        ex_mem_to_reg = 1'b0, ex_lui = 1'b0, ex_unsigned = 1'b0, ex_reg_write = 1'b0;
    logic [1:0]  ex_size = 2'b00;
    logic [31:0] ex_addr = '0, ex_wdata = '0, ex_lui_field = '0;
    logic [4:0]  ex_rd = '0;
    logic        stall, mem_req, mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_valid, wb_reg_write, exc_misalign, exc_timeout;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit        ld, st, m2r, lui, uns, rw;
        bit [1:0]  sz;
        bit [31:0] addr, wdata, luif;
        bit [4:0]  rd;
    } instr_t;

    mem_stage_lsu #(.TIMEOUT(TO), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_lui(ex_lui),
        .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_lui_field(ex_lui_field), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .exc_misalign(exc_misalign), .exc_timeout(exc_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input bit [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic int lane_base(input bit [1:0] sz, input bit [31:0] a);
        int nb = nbytes(sz);
        return ((a % 4) / nb) * nb;
    endfunction

    function automatic logic [3:0] ref_be(input bit [1:0] sz, input bit [31:0] a);
        int nb = nbytes(sz);
        int v  = ((1 << nb) - 1) << lane_base(sz, a);
        return 4'(v);
    endfunction

    function automatic logic [31:0] ref_rep(input bit [1:0] sz, input bit [31:0] wd);
        int     nb  = nbytes(sz);
        longint pat = longint'(wd) % (longint'(1) << (8 * nb));
        longint r   = 0;
        for (int i = 0; i < 4 / nb; i++) r += pat << (8 * nb * i);
        return r[31:0];
    endfunction

    function automatic logic [31:0] ref_load(input bit [1:0] sz, input bit [31:0] a,
                                             input bit uns, input logic [31:0] rd);
        int     nb = nbytes(sz);
        longint v  = (longint'(rd) >> (8 * lane_base(sz, a))) % (longint'(1) << (8 * nb));
        if (!uns && v >= (longint'(1) << (8 * nb - 1))) v -= (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    function automatic instr_t mk(input bit ld, input bit st, input bit [1:0] sz, input bit uns,
                                  input bit [31:0] addr, input bit [31:0] wd, input bit [4:0] rd);
        instr_t in;
        in.ld = ld; in.st = st; in.sz = sz; in.uns = uns; in.addr = addr; in.wdata = wd;
        in.rd = rd; in.m2r = ld; in.rw = !st; in.lui = 1'b0; in.luif = 32'h0;
        return in;
    endfunction

    task automatic drive(input instr_t in, input bit v);
        ex_valid = v; ex_mem_read = in.ld; ex_mem_write = in.st; ex_mem_to_reg = in.m2r;
        ex_lui = in.lui; ex_size = in.sz; ex_unsigned = in.uns; ex_addr = in.addr;
        ex_wdata = in.wdata; ex_lui_field = in.luif; ex_rd = in.rd; ex_reg_write = in.rw;
    endtask

    // One instruction end to end; ack_dly = ACCESS cycles before the ack cycle (>=TO: none).
    task automatic run_op(input instr_t in, input int ack_dly, input logic [31:0] rdata,
                          output int stall_cyc, output logic [31:0] wb_obs);
        bit is_st = in.st;
        bit is_ld = in.ld && !in.st;
        bit is_mem = is_st || is_ld;
        bit mis = is_mem && ((in.addr % nbytes(in.sz)) != 0);
        bit acked = 1'b0;
        bit exp_rw;
        stall_cyc = 0;
        @(negedge clk);
        drive(in, 1'b1);
        @(negedge clk);
        ex_valid = 1'b0;
        if (is_mem && !mis) begin
            chk("mem_we", 64'(mem_we), 64'(is_st));
            chk("mem_addr", 64'(mem_addr), 64'(in.addr >> 2));
            if (is_st) chk("mem_wdata", 64'(mem_wdata), 64'(ref_rep(in.sz, in.wdata)));
            for (int c = 0; c < TO && !acked; c++) begin
                chk("access_hold", {58'h0, stall, mem_req, mem_be},
                    {58'h0, 2'b11, ref_be(in.sz, in.addr)});
                stall_cyc++;
                if (c == ack_dly) begin
                    mem_ack = 1'b1; mem_rdata = rdata; acked = 1'b1;
                end
                @(negedge clk);
                mem_ack = 1'b0; mem_rdata = $urandom;
            end
        end
        exp_rw = !is_mem ? in.rw : (is_ld && acked) ? in.rw : 1'b0;
        chk("idle_after", {62'h0, stall, mem_req}, 64'h0);
        chk("wb_valid", 64'(wb_valid), 64'h1);
        chk("wb_rd", 64'(wb_rd), 64'(in.rd));
        chk("wb_reg_write", 64'(wb_reg_write), 64'(exp_rw));
        chk("exc_misalign", 64'(exc_misalign), 64'(mis));
        chk("exc_timeout", 64'(exc_timeout), 64'(is_mem && !mis && !acked));
        if (!is_mem)
            chk("wb_data_alu", 64'(wb_data), 64'(in.lui ? in.luif : in.addr));
        else if (is_ld && acked)
            chk("wb_data_ld", 64'(wb_data),
                64'(in.m2r ? ref_load(in.sz, in.addr, in.uns, rdata) : in.addr));
        wb_obs = wb_data;
        @(negedge clk);
        chk("wb_pulse", {61'h0, wb_valid, exc_misalign, exc_timeout}, 64'h0);
    endtask

    initial begin
        instr_t      in, lu;
        int          sc;
        logic [31:0] wo;

        repeat (2) @(negedge clk);
        chk("rst_ctrl", {56'h0, stall, mem_req, mem_we, wb_valid, wb_reg_write, exc_misalign,
                         exc_timeout, 1'b0}, 64'h0);
        chk("rst_data", {mem_addr, mem_be, wb_data}, 64'h0);
        chk("rst_wdata", {32'h0, mem_wdata}, 64'h0);
        rst_n = 1'b1;

        // Load word, ack in second ACCESS cycle.
        run_op(mk(1, 0, 2'd2, 0, 32'h10, 32'h0, 5'd3), 1, 32'hDEADBEEF, sc, wo);
        chk("t1_stall_cycles", 64'(sc), 64'd2);
        chk("t1_wb_data", 64'(wo), 64'hDEADBEEF);

        run_op(mk(1, 0, 2'd0, 0, 32'h13, 32'h0, 5'd4), 0, 32'h80FFFF7F, sc, wo);
        chk("t2_lb", 64'(wo), 64'hFFFFFF80);
        run_op(mk(1, 0, 2'd0, 1, 32'h13, 32'h0, 5'd4), 0, 32'h80FFFF7F, sc, wo);
        chk("t2_lbu", 64'(wo), 64'h00000080);
        run_op(mk(1, 0, 2'd1, 0, 32'h12, 32'h0, 5'd4), 2, 32'h80FFFF7F, sc, wo);
        chk("t2_lh", 64'(wo), 64'hFFFF80FF);

        // Store half: check request fields before the ack.
        @(negedge clk);
        drive(mk(0, 1, 2'd1, 0, 32'h22, 32'h1234ABCD, 5'd9), 1'b1);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("t3_req", {28'h0, mem_req, mem_we, mem_be, mem_wdata}, {28'h0, 2'b11, 4'b1100,
                                                                      32'hABCDABCD});
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("t3_wb", {62'h0, wb_valid, wb_reg_write}, 64'h2);

        run_op(mk(1, 0, 2'd2, 0, 32'h06, 32'h0, 5'd5), 0, 32'h0, sc, wo);
        chk("t4_no_req_cycles", 64'(sc), 64'd0);
        run_op(mk(0, 0, 2'd2, 0, 32'h55, 32'h0, 5'd6), 0, 32'h0, sc, wo);
        chk("t4_alu", 64'(wo), 64'h55);

        // Ack on the last allowed cycle wins, then a full timeout.
        run_op(mk(1, 0, 2'd2, 0, 32'h80, 32'h0, 5'd1), TO - 1, 32'h0BADF00D, sc, wo);
        chk("t5_ack_last", 64'(wo), 64'h0BADF00D);
        run_op(mk(1, 0, 2'd2, 0, 32'h84, 32'h0, 5'd2), 99, 32'h0, sc, wo);
        chk("t5_to_cycles", 64'(sc), 64'(TO));
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("t5_late_ack", {61'h0, wb_valid, stall, mem_req}, 64'h0);

        // LUI held behind a pending load must write back second.
        lu = mk(0, 0, 2'd2, 0, 32'h99, 32'h0, 5'd7);
        lu.lui = 1'b1; lu.luif = 32'h12340000;
        @(negedge clk);
        drive(mk(1, 0, 2'd2, 0, 32'h40, 32'h0, 5'd8), 1'b1);
        @(negedge clk);
        drive(lu, 1'b1);
        chk("t6_stall", 64'(stall), 64'h1);
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("t6_first", {27'h0, wb_valid, stall, wb_rd, wb_data}, {27'h0, 2'b10, 5'd8,
                                                                    32'hCAFEF00D});
        @(negedge clk);
        ex_valid = 1'b0;
        chk("t6_second", {28'h0, wb_valid, wb_rd, wb_data}, {28'h0, 1'b1, 5'd7, 32'h12340000});

        // Reset mid-access drops the request asynchronously.
        @(negedge clk);
        drive(mk(1, 0, 2'd2, 0, 32'h50, 32'h0, 5'd8), 1'b1);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("t6_pre_rst", 64'(mem_req), 64'h1);
        #2 rst_n = 1'b0;
        #1 chk("t6_async_rst", {61'h0, mem_req, stall, wb_valid}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("t6_ack_after_rst", {61'h0, wb_valid, stall, mem_req}, 64'h0);

        // Random mix of ALU, loads, stores, misaligned ops and timeouts.
        for (int n = 0; n < 60; n++) begin
            int kind = $urandom_range(0, 2);
            int dly  = $urandom_range(0, 3);
            in = mk(kind == 1, kind == 2, 2'($urandom_range(0, 3)), 1'($urandom),
                    $urandom, $urandom, 5'($urandom));
            if (kind == 2) in.ld = 1'($urandom);
            in.m2r = 1'($urandom); in.rw = 1'($urandom);
            in.lui = 1'($urandom); in.luif = $urandom;
            if ($urandom_range(0, 3) != 0)
                in.addr = in.addr & ~32'(nbytes(in.sz) - 1);
            if ($urandom_range(0, 11) == 0) dly = 99;
            run_op(in, dly, $urandom, sc, wo);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
